dmem_sramlike_if: RTL and testbench
===================================

# dmem_sramlike_if

Data-side memory interface for the M stage, directly downstream of the load/store byte-select stage. It turns the stage's access request into a transaction on the SRAM-like data bus: address, size, write-enable and replicated write data go out, and the read word comes back. It holds the pipeline stalled until the transaction completes, and keeps the returned word stable while other stall sources freeze the pipeline.

## Interface
- `DMEM_KSEG_MAP_EN`: undefined by default; enables the fixed kseg0/kseg1 virtual-to-physical mapping.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_en` in 1: M-stage instruction is a load or store.
- `mem_wen` in 1: access is a store.
- `addr` in 32: virtual byte address, equal to the ALU output in M.
- `sel` in 4: byte lanes; informational only, not driven on the bus.
- `size` in 2: 00 byte, 01 half, 10 word.
- `wdata` in 32: lane-replicated store data.
- `except_flush` in 1: exception detected in M this cycle.
- `stall_other` in 1: pipeline frozen by another source.
- `rdata` out 32: read word returned to the select stage.
- `stall_req` out 1: this block stalls the pipeline.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write.
- `data_size` out 2: bus size.
- `data_addr` out 32: bus address.
- `data_wdata` out 32: bus write data.
- `data_addr_ok` in 1: request accepted.
- `data_data_ok` in 1: read data valid or write done.
- `data_rdata` in 32: bus read data.

## Operation
- FSM states: IDLE, ADDR (request out, waiting `data_addr_ok`), DATA (accepted, waiting `data_data_ok`), HOLD (done, pipeline still frozen).
- Issue condition in IDLE: `mem_en & ~except_flush`.
- IDLE with the issue condition:
  - `data_req`=1 combinationally, with bus fields driven from the inputs.
  - `addr`, `size`, `mem_wen` and `wdata` are registered into request latches.
  - Next state is DATA if `data_addr_ok`, otherwise ADDR.
- ADDR:
  - `data_req`=1, with bus fields driven from the latches.
  - Once asserted, `data_req` is never retracted before `data_addr_ok`.
  - `data_addr_ok` moves the state to DATA.
- DATA:
  - `data_req`=0.
  - On `data_data_ok`: capture `data_rdata` into `rdata_r`. Next state is HOLD if `stall_other`, otherwise IDLE.
- HOLD: next state is IDLE when `stall_other`=0. No new request is issued while in HOLD.
- `stall_req`:
  - 1 in IDLE when the issue condition holds.
  - 1 in ADDR.
  - 1 in DATA while `data_data_ok`=0.
  - 0 otherwise.
- `rdata`: equals `data_rdata` in the completion cycle (bypass), otherwise `rdata_r`.
- `except_flush` in ADDR or DATA does not cancel the transaction: it completes and the pipeline discards the result. `stall_req` follows the normal rules.
- `data_data_ok` outside DATA and `data_addr_ok` outside IDLE/ADDR are ignored.
- Reset (asynchronous) takes the state to IDLE and clears the latches and `rdata_r`. The bus side is reset by the same `rst`, so there is no outstanding transaction to drain.

## Timing
- Reset values: `rdata`=0, `stall_req`=0, `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wdata`=0.
- Minimum latency is 2 cycles: issue and accept in cycle 0, `data_data_ok` in cycle 1. `stall_req` is high in cycle 0 and low in cycle 1.
- The slave never asserts `data_data_ok` in the same cycle as the accepting `data_addr_ok`.
- Back-to-back accesses: after the completion edge the state is IDLE, so the next M-stage access issues in the following cycle.

## Configuration
- `DMEM_KSEG_MAP_EN` defined:
  - `data_addr` = {3'b000, addr[28:0]} when addr[31:30]=2'b10 (kseg0 and kseg1).
  - All other addresses pass through unchanged.
- Undefined: `data_addr` = `addr` unmodified.

## Test plan
- Load word at 0x8000_0010 with `data_addr_ok` in the same cycle and `data_data_ok`=1 one cycle later with rdata 0xDEAD_BEEF:
  - `stall_req` is high for exactly 1 cycle and `rdata`=0xDEAD_BEEF in the completion cycle.
  - `data_addr`=0x0000_0010 with the macro defined, 0x8000_0010 without.
- Store byte, `wdata`=0x5A5A_5A5A, `addr`=0x0000_0003, `data_addr_ok` delayed 3 cycles:
  - `data_req` is held for 4 cycles with stable `data_addr`, `data_wr`=1, `data_size`=00.
- `mem_en`=1 with `except_flush`=1 in IDLE:
  - `data_req` stays 0, `stall_req` stays 0, and the state remains IDLE.
- Load completes while `stall_other`=1 for 3 more cycles:
  - State goes to HOLD, `rdata` is held at the captured value, `stall_req`=0, and no new `data_req` is issued until `stall_other` falls.
- `rst` asserted while in DATA:
  - All outputs drop to 0 asynchronously, and the next access issues normally after reset is released.
- Two consecutive loads:
  - The second `data_req` rises in the cycle immediately after the first completion edge.

Source files
------------

// File: rtl/dmem_sramlike_if_if.sv
// SRAM-like data bus bundle between the M-stage memory interface (master)
// and the data memory / bus bridge (slave).
interface dmem_sramlike_if_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/dmem_sramlike_if.sv
// M-stage data memory interface: turns a load/store request into an
// SRAM-like bus transaction, stalls the pipeline until it completes and
// keeps the returned word stable while other stall sources hold the pipe.
// Optional macro DMEM_KSEG_MAP_EN: when defined, kseg0/kseg1 virtual
// addresses (addr[31:30] == 2'b10) are mapped to physical by clearing
// the top three bits; otherwise the address passes through unchanged.
module dmem_sramlike_if (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_mem_en,
  input  logic                     i_mem_wen,
  input  logic [31:0]              i_addr,
  input  logic [3:0]               i_sel,
  input  logic [1:0]               i_size,
  input  logic [31:0]              i_wdata,
  input  logic                     i_except_flush,
  input  logic                     i_stall_other,
  output logic [31:0]              o_rdata,
  output logic                     o_stall_req,
  dmem_sramlike_if_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_reqAddr;
  logic [1:0]  r_reqSize;
  logic        r_reqWr;
  logic [31:0] r_reqWdata;
  logic [31:0] r_rdata;

  logic        w_issue;
  logic        w_complete;
  logic [31:0] w_rawAddr;
  logic        w_unused_sel;

  // Byte lanes are carried for the select stage only; the bus uses size.
  assign w_unused_sel = ^i_sel;

  // Virtual-to-physical translation applied on the way out to the bus.
  function automatic logic [31:0] mapAddr(input logic [31:0] a);
`ifdef DMEM_KSEG_MAP_EN
    if (a[31:30] == 2'b10) begin
      return {3'b000, a[28:0]};
    end else begin
      return a;
    end
`else
    return a;
`endif
  endfunction

  // Rst gating keeps every bus output at zero while reset is asserted.
  assign w_issue    = (r_state == IDLE) & i_mem_en & ~i_except_flush & ~rst;
  assign w_complete = (r_state == DATA) & bus.data_data_ok;

  // Transaction sequencing, request latches and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_reqAddr  <= 32'd0;
      r_reqSize  <= 2'd0;
      r_reqWr    <= 1'b0;
      r_reqWdata <= 32'd0;
      r_rdata    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_reqAddr  <= i_addr;
            r_reqSize  <= i_size;
            r_reqWr    <= i_mem_wen;
            r_reqWdata <= i_wdata;
            r_state    <= bus.data_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          if (bus.data_addr_ok) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (bus.data_data_ok) begin
            r_rdata <= bus.data_rdata;
            r_state <= i_stall_other ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!i_stall_other) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus fields come straight from the inputs in the issue cycle so the
  // request costs no extra cycle, and from the latches afterwards so they
  // stay stable until accepted even if the M-stage inputs wander.
  always_comb begin
    w_rawAddr      = r_reqAddr;
    bus.data_req   = 1'b0;
    bus.data_wr    = r_reqWr;
    bus.data_size  = r_reqSize;
    bus.data_wdata = r_reqWdata;
    if (w_issue) begin
      w_rawAddr      = i_addr;
      bus.data_req   = 1'b1;
      bus.data_wr    = i_mem_wen;
      bus.data_size  = i_size;
      bus.data_wdata = i_wdata;
    end else if (r_state == ADDR) begin
      bus.data_req   = 1'b1;
    end
    bus.data_addr = mapAddr(w_rawAddr);
  end

  // Stall until the data phase finishes; read word bypasses on completion.
  always_comb begin
    o_stall_req = w_issue
                | (r_state == ADDR)
                | ((r_state == DATA) & ~bus.data_data_ok);
    o_rdata     = w_complete ? bus.data_rdata : r_rdata;
  end

endmodule

// File: tb/tb_dmem_sramlike_if.sv
// Directed testbench for dmem_sramlike_if with a queue-based scoreboard:
// the stimulus pushes expected bus requests and read words, and a separate
// monitor pops and compares whenever the bus accepts or completes.
module tb_dmem_sramlike_if;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

`ifdef DMEM_KSEG_MAP_EN
  localparam logic [31:0] EXP_ADDR_K0 = 32'h0000_0010;
  localparam logic [31:0] EXP_ADDR_K1 = 32'h0000_0020;
`else
  localparam logic [31:0] EXP_ADDR_K0 = 32'h8000_0010;
  localparam logic [31:0] EXP_ADDR_K1 = 32'hA000_0020;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic        except_flush;
  logic        stall_other;
  logic [31:0] rdata;
  logic        stall_req;

  int nVectors = 0;
  int nMiscompares = 0;

  req_t        reqQ[$];
  logic [31:0] rdQ[$];

  dmem_sramlike_if_if bus ();

  dmem_sramlike_if dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_en       (mem_en),
    .i_mem_wen      (mem_wen),
    .i_addr         (addr),
    .i_sel          (sel),
    .i_size         (size),
    .i_wdata        (wdata),
    .i_except_flush (except_flush),
    .i_stall_other  (stall_other),
    .o_rdata        (rdata),
    .o_stall_req    (stall_req),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic wen,
                               input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] wd, input logic flush,
                               input logic so, input logic aok,
                               input logic dok, input logic [31:0] brd);
    @(posedge clk);
    #1;
    mem_en           = en;
    mem_wen          = wen;
    addr             = a;
    size             = sz;
    wdata            = wd;
    except_flush     = flush;
    stall_other      = so;
    bus.data_addr_ok = aok;
    bus.data_data_ok = dok;
    bus.data_rdata   = brd;
  endtask

  task automatic pushReq(input logic [31:0] a, input logic wr,
                         input logic [1:0] sz, input logic [31:0] wd);
    req_t r;
    r.addr  = a;
    r.wr    = wr;
    r.size  = sz;
    r.wdata = wd;
    reqQ.push_back(r);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rdata"},      rdata,          32'd0);
    checkOutput({tag, " stall_req"},  {31'd0, stall_req}, 32'd0);
    checkOutput({tag, " data_req"},   {31'd0, bus.data_req}, 32'd0);
    checkOutput({tag, " data_wr"},    {31'd0, bus.data_wr}, 32'd0);
    checkOutput({tag, " data_size"},  {30'd0, bus.data_size}, 32'd0);
    checkOutput({tag, " data_addr"},  bus.data_addr,  32'd0);
    checkOutput({tag, " data_wdata"}, bus.data_wdata, 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    mem_en           = 1'b0;
    mem_wen          = 1'b0;
    addr             = 32'd0;
    sel              = 4'hF;
    size             = 2'd0;
    wdata            = 32'd0;
    except_flush     = 1'b0;
    stall_other      = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'd0;

    fork
      begin : monitorProc
        req_t        r;
        logic [31:0] e;
        forever begin
          @(negedge clk);
          if (bus.data_req && bus.data_addr_ok) begin
            if (reqQ.size() == 0) begin
              checkOutput("unexpected accept", 32'd1, 32'd0);
            end else begin
              r = reqQ.pop_front();
              checkOutput("req addr",  bus.data_addr, r.addr);
              checkOutput("req wr",    {31'd0, bus.data_wr}, {31'd0, r.wr});
              checkOutput("req size",  {30'd0, bus.data_size}, {30'd0, r.size});
              checkOutput("req wdata", bus.data_wdata, r.wdata);
            end
          end
          if (bus.data_data_ok) begin
            if (rdQ.size() == 0) begin
              checkOutput("unexpected data_ok", 32'd1, 32'd0);
            end else begin
              e = rdQ.pop_front();
              checkOutput("completion rdata", rdata, e);
            end
          end
        end
      end
      begin : stimProc
        // Reset values
        @(negedge clk);
        checkAllZero("reset");
        applyStimulus(0, 0, 32'd0, 2'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle data_req", {31'd0, bus.data_req}, 32'd0);

        // Load word kseg0, accepted at issue, data one cycle later
        applyStimulus(1, 0, 32'h8000_0010, 2'b10, 32'd0, 0, 0, 1, 0, 32'd0);
        pushReq(EXP_ADDR_K0, 1'b0, 2'b10, 32'd0);
        @(negedge clk);
        checkOutput("lw c0 stall_req", {31'd0, stall_req}, 32'd1);
        checkOutput("lw c0 data_req", {31'd0, bus.data_req}, 32'd1);
        applyStimulus(1, 0, 32'h8000_0010, 2'b10, 32'd0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        rdQ.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("lw c1 stall_req", {31'd0, stall_req}, 32'd0);
        checkOutput("lw c1 data_req", {31'd0, bus.data_req}, 32'd0);
        checkOutput("lw c1 rdata", rdata, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 32'd0, 2'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        checkOutput("lw held rdata", rdata, 32'hDEAD_BEEF);

        // Store byte with accept delayed three cycles; inputs wander meanwhile
        applyStimulus(1, 1, 32'h0000_0003, 2'b00, 32'h5A5A_5A5A, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        checkOutput("sb c0 data_req", {31'd0, bus.data_req}, 32'd1);
        checkOutput("sb c0 data_addr", bus.data_addr, 32'h0000_0003);
        checkOutput("sb c0 data_wr", {31'd0, bus.data_wr}, 32'd1);
        checkOutput("sb c0 data_size", {30'd0, bus.data_size}, 32'd0);
        for (int i = 0; i < 3; i++) begin
          applyStimulus(1, 1, 32'hFFFF_FFF0, 2'b10, 32'd0, 0, 0, (i == 2), 0, 32'd0);
          if (i == 2) pushReq(32'h0000_0003, 1'b1, 2'b00, 32'h5A5A_5A5A);
          @(negedge clk);
          checkOutput("sb wait data_req", {31'd0, bus.data_req}, 32'd1);
          checkOutput("sb wait data_addr", bus.data_addr, 32'h0000_0003);
          checkOutput("sb wait data_wr", {31'd0, bus.data_wr}, 32'd1);
          checkOutput("sb wait data_size", {30'd0, bus.data_size}, 32'd0);
          checkOutput("sb wait stall_req", {31'd0, stall_req}, 32'd1);
        end
        applyStimulus(1, 1, 32'hFFFF_FFF0, 2'b10, 32'd0, 0, 0, 0, 1, 32'h1234_5678);
        rdQ.push_back(32'h1234_5678);
        @(negedge clk);
        checkOutput("sb done stall_req", {31'd0, stall_req}, 32'd0);
        checkOutput("sb done data_req", {31'd0, bus.data_req}, 32'd0);

        // Flushed access never issues
        for (int i = 0; i < 2; i++) begin
          applyStimulus(1, 0, 32'h0000_0100, 2'b10, 32'd0, 1, 0, 0, 0, 32'd0);
          @(negedge clk);
          checkOutput("flush data_req", {31'd0, bus.data_req}, 32'd0);
          checkOutput("flush stall_req", {31'd0, stall_req}, 32'd0);
        end
        // Still IDLE: the unflushed access issues immediately
        applyStimulus(1, 0, 32'h0000_0100, 2'b10, 32'd0, 0, 0, 1, 0, 32'd0);
        pushReq(32'h0000_0100, 1'b0, 2'b10, 32'd0);
        @(negedge clk);
        checkOutput("post-flush data_req", {31'd0, bus.data_req}, 32'd1);
        checkOutput("post-flush stall_req", {31'd0, stall_req}, 32'd1);

        // Completion under an external stall, then three held cycles
        applyStimulus(1, 0, 32'h0000_0100, 2'b10, 32'd0, 0, 1, 0, 1, 32'hCAFE_F00D);
        rdQ.push_back(32'hCAFE_F00D);
        @(negedge clk);
        checkOutput("hold c0 stall_req", {31'd0, stall_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
          applyStimulus(1, 0, 32'h0000_0100, 2'b10, 32'd0, 0, 1, 0, 0, 32'hBAD0_BAD0);
          @(negedge clk);
          checkOutput("hold data_req", {31'd0, bus.data_req}, 32'd0);
          checkOutput("hold stall_req", {31'd0, stall_req}, 32'd0);
          checkOutput("hold rdata", rdata, 32'hCAFE_F00D);
        end
        applyStimulus(1, 0, 32'h0000_0100, 2'b10, 32'd0, 0, 0, 0, 0, 32'hBAD0_BAD0);
        @(negedge clk);
        checkOutput("hold exit data_req", {31'd0, bus.data_req}, 32'd0);
        checkOutput("hold exit rdata", rdata, 32'hCAFE_F00D);

        // Two back-to-back loads, first one in kseg1
        applyStimulus(1, 0, 32'hA000_0020, 2'b10, 32'd0, 0, 0, 1, 0, 32'd0);
        pushReq(EXP_ADDR_K1, 1'b0, 2'b10, 32'd0);
        @(negedge clk);
        checkOutput("b2b first data_req", {31'd0, bus.data_req}, 32'd1);
        applyStimulus(1, 0, 32'hA000_0020, 2'b10, 32'd0, 0, 0, 0, 1, 32'h1111_1111);
        rdQ.push_back(32'h1111_1111);
        @(negedge clk);
        checkOutput("b2b first stall_req", {31'd0, stall_req}, 32'd0);
        applyStimulus(1, 0, 32'h0000_0040, 2'b10, 32'd0, 0, 0, 1, 0, 32'd0);
        pushReq(32'h0000_0040, 1'b0, 2'b10, 32'd0);
        @(negedge clk);
        checkOutput("b2b second data_req", {31'd0, bus.data_req}, 32'd1);
        applyStimulus(1, 0, 32'h0000_0040, 2'b10, 32'd0, 0, 0, 0, 1, 32'h2222_2222);
        rdQ.push_back(32'h2222_2222);
        @(negedge clk);
        checkOutput("b2b second stall_req", {31'd0, stall_req}, 32'd0);

        // Asynchronous reset while waiting for data
        applyStimulus(1, 0, 32'h0000_0200, 2'b10, 32'h0000_0077, 0, 0, 1, 0, 32'd0);
        pushReq(32'h0000_0200, 1'b0, 2'b10, 32'h0000_0077);
        @(negedge clk);
        applyStimulus(1, 0, 32'h0000_0200, 2'b10, 32'h0000_0077, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        checkOutput("data-wait stall_req", {31'd0, stall_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        applyStimulus(1, 0, 32'h0000_0300, 2'b10, 32'd0, 0, 0, 1, 0, 32'd0);
        rst = 1'b0;
        pushReq(32'h0000_0300, 1'b0, 2'b10, 32'd0);
        @(negedge clk);
        checkOutput("post-reset data_req", {31'd0, bus.data_req}, 32'd1);
        checkOutput("post-reset stall_req", {31'd0, stall_req}, 32'd1);
        applyStimulus(1, 0, 32'h0000_0300, 2'b10, 32'd0, 0, 0, 0, 1, 32'h3333_3333);
        rdQ.push_back(32'h3333_3333);
        @(negedge clk);
        checkOutput("post-reset done stall_req", {31'd0, stall_req}, 32'd0);
        applyStimulus(0, 0, 32'd0, 2'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        checkOutput("post-reset held rdata", rdata, 32'h3333_3333);
        applyStimulus(0, 0, 32'd0, 2'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
      end
    join_any

    checkOutput("requests left in queue", reqQ.size(), 32'd0);
    checkOutput("reads left in queue", rdQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
